// File: rtl/interrupt_sequencer.sv
// 6502 interrupt entry sequencer (RESET/NMI/IRQ/BRK) for the NES CPU core.
// Owns the bus for seven cycles plus a PC-load cycle; every output is a flop.
//
// state  | meaning
// IDLE   | waiting for a trigger; bus idle (busy held while reset is pending)
// T0     | dummy read at return address
// T1     | dummy read at return address
// T2     | push return address high byte
// T3     | push return address low byte
// T4     | push status; vector chosen at end of this cycle
// T5     | read vector low byte, set I, clear pulses
// T6     | read vector high byte
// LOAD   | present new PC with pc_load pulse
module interrupt_sequencer #(
    parameter logic [7:0]  STACK_PAGE = 8'h01,
    parameter logic [15:0] VEC_NMI    = 16'hFFFA,
    parameter logic [15:0] VEC_RST    = 16'hFFFC,
    parameter logic [15:0] VEC_IRQ    = 16'hFFFE
) (
    input  logic        clk_ph2,
    input  logic        rst,
    input  logic        inst_end,
    input  logic        brk_start,
    input  logic        irq_req,
    input  logic        nmi_req,
    input  logic [15:0] pc_in,
    input  logic [7:0]  sp_in,
    input  logic [7:0]  p_in,
    input  logic [7:0]  din,
    output logic        busy,
    output logic [15:0] addr,
    output logic [7:0]  dout,
    output logic        rw,
    output logic        sp_dec,
    output logic        set_i,
    output logic        pc_load,
    output logic [15:0] pc_out,
    output logic        nmi_clr,
    output logic        irq_clr
);

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_LOAD
    } state_t;

    typedef enum logic [1:0] {K_RST, K_NMI, K_IRQ, K_BRK} kind_t;

    state_t      state, state_n;
    kind_t       kind, kind_n;
    logic        rst_pend, rst_pend_n;
    logic [15:0] ret, ret_n;
    logic [15:0] vec, vec_n;
    logic [7:0]  sp, sp_n;
    logic [7:0]  ps, ps_n;
    logic [7:0]  lo, lo_n;

    logic        busy_n, rw_n, sp_dec_n, set_i_n, pc_load_n, nmi_clr_n, irq_clr_n;
    logic [15:0] addr_n, pc_out_n;
    logic [7:0]  dout_n;

    always_ff @(posedge clk_ph2) begin
        if (!rst) begin
            state    <= S_IDLE;
            kind     <= K_RST;
            rst_pend <= 1'b1;
            ret      <= '0;
            vec      <= '0;
            sp       <= '0;
            ps       <= '0;
            lo       <= '0;
            busy     <= 1'b1;
            addr     <= '0;
            dout     <= '0;
            rw       <= 1'b1;
            sp_dec   <= 1'b0;
            set_i    <= 1'b0;
            pc_load  <= 1'b0;
            pc_out   <= '0;
            nmi_clr  <= 1'b0;
            irq_clr  <= 1'b0;
        end else begin
            state    <= state_n;
            kind     <= kind_n;
            rst_pend <= rst_pend_n;
            ret      <= ret_n;
            vec      <= vec_n;
            sp       <= sp_n;
            ps       <= ps_n;
            lo       <= lo_n;
            busy     <= busy_n;
            addr     <= addr_n;
            dout     <= dout_n;
            rw       <= rw_n;
            sp_dec   <= sp_dec_n;
            set_i    <= set_i_n;
            pc_load  <= pc_load_n;
            pc_out   <= pc_out_n;
            nmi_clr  <= nmi_clr_n;
            irq_clr  <= irq_clr_n;
        end
    end

    // Next state and next values of the sequence registers.
    always_comb begin
        state_n    = state;
        kind_n     = kind;
        rst_pend_n = rst_pend;
        ret_n      = ret;
        vec_n      = vec;
        sp_n       = sp;
        ps_n       = ps;
        lo_n       = lo;
        case (state)
            S_IDLE: begin
                if (rst_pend) begin
                    state_n    = S_T0;
                    kind_n     = K_RST;
                    rst_pend_n = 1'b0;
                end else if (inst_end && nmi_req) begin
                    state_n = S_T0;
                    kind_n  = K_NMI;
                end else if (inst_end && irq_req) begin
                    state_n = S_T0;
                    kind_n  = K_IRQ;
                end else if (brk_start) begin
                    state_n = S_T0;
                    kind_n  = K_BRK;
                end
                // Capture is harmless when nothing triggers: the values are unused in IDLE.
                ret_n = (kind_n == K_BRK) ? pc_in + 16'd2 : pc_in;
                sp_n  = sp_in;
                ps_n  = p_in;
            end
            S_T0: state_n = S_T1;
            S_T1: state_n = S_T2;
            S_T2: begin
                state_n = S_T3;
                sp_n    = sp - 8'd1;
            end
            S_T3: begin
                state_n = S_T4;
                sp_n    = sp - 8'd1;
            end
            S_T4: begin
                state_n = S_T5;
                sp_n    = sp - 8'd1;
                if (kind == K_RST)
                    vec_n = VEC_RST;
                else if (nmi_req)
                    vec_n = VEC_NMI;
                else
                    vec_n = VEC_IRQ;
            end
            S_T5: begin
                state_n = S_T6;
                lo_n    = din;
            end
            S_T6:    state_n = S_LOAD;
            S_LOAD:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Outputs for the cycle about to begin, derived from the next state.
    always_comb begin
        busy_n    = (state_n != S_IDLE) || rst_pend_n;
        addr_n    = '0;
        dout_n    = '0;
        rw_n      = 1'b1;
        sp_dec_n  = 1'b0;
        set_i_n   = 1'b0;
        pc_load_n = 1'b0;
        pc_out_n  = pc_out;
        nmi_clr_n = 1'b0;
        irq_clr_n = 1'b0;
        case (state_n)
            S_T0, S_T1: addr_n = ret_n;
            S_T2: begin
                addr_n   = {STACK_PAGE, sp_n};
                sp_dec_n = 1'b1;
                if (kind_n != K_RST) begin
                    rw_n   = 1'b0;
                    dout_n = ret_n[15:8];
                end
            end
            S_T3: begin
                addr_n   = {STACK_PAGE, sp_n};
                sp_dec_n = 1'b1;
                if (kind_n != K_RST) begin
                    rw_n   = 1'b0;
                    dout_n = ret_n[7:0];
                end
            end
            S_T4: begin
                addr_n   = {STACK_PAGE, sp_n};
                sp_dec_n = 1'b1;
                if (kind_n != K_RST) begin
                    rw_n   = 1'b0;
                    dout_n = {ps_n[7:6], 1'b1, (kind_n == K_BRK), ps_n[3:0]};
                end
            end
            S_T5: begin
                addr_n    = vec_n;
                set_i_n   = 1'b1;
                nmi_clr_n = (vec_n == VEC_NMI);
                irq_clr_n = (kind_n == K_IRQ) && (vec_n == VEC_IRQ);
            end
            S_T6: addr_n = vec_n + 16'd1;
            S_LOAD: begin
                pc_load_n = 1'b1;
                pc_out_n  = {din, lo_n};
            end
            default: ;
        endcase
    end

endmodule
